// File: rtl/array_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : array_allocator
//  Description : Shared array-handle allocator. Hands out identifiers on
//                request and recycles freed identifiers through a LIFO free
//                stack. Reports exhaustion and illegal frees, and supports a
//                same-cycle alloc+free bypass. Keeps occupancy statistics:
//                in-use count, fresh-pool count and high-water mark.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_allocator #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alloc_req,
  output logic                          alloc_done,
  output logic                          alloc_ok,
  output logic [MemoryElementWidth-1:0] alloc_id,
  input  logic                          free_req,
  input  logic [MemoryElementWidth-1:0] free_id,
  output logic                          free_done,
  output logic                          free_ok,
  output logic [MemoryElementWidth-1:0] in_use,
  output logic [MemoryElementWidth-1:0] fresh,
  output logic [MemoryElementWidth-1:0] high_water,
  output logic                          err_sticky
);

  // Index width addresses one slot of the stack or the bitmap. Count width
  // must be able to hold NArrays itself (full stack, fully drained pool).
  localparam int c_idx_w = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int c_cnt_w = $clog2(NArrays + 1);
  localparam int c_lim_w = MemoryElementWidth + 1;

  localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(NArrays);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_lim_w-1:0] c_id_limit = c_lim_w'(NArrays);

  // Architectural state
  logic [MemoryElementWidth-1:0] r_freed [NArrays];
  logic [c_cnt_w-1:0]            r_top;
  logic [c_cnt_w-1:0]            r_fresh;
  logic [c_cnt_w-1:0]            r_in_use;
  logic [c_cnt_w-1:0]            r_high_water;
  logic [NArrays-1:0]            r_live;

  // Registered outputs
  logic                          r_alloc_done;
  logic                          r_alloc_ok;
  logic [MemoryElementWidth-1:0] r_alloc_id;
  logic                          r_free_done;
  logic                          r_free_ok;
  logic                          r_err;

  // Decode of the current request pair
  logic [c_idx_w-1:0]            w_free_idx;
  logic [c_idx_w-1:0]            w_pop_idx;
  logic [c_idx_w-1:0]            w_push_idx;
  logic [c_idx_w-1:0]            w_alloc_idx;
  logic                          w_free_in_range;
  logic                          w_free_legal;
  logic                          w_bypass;
  logic                          w_stack_nonempty;
  logic                          w_fresh_avail;
  logic                          w_pop;
  logic                          w_take_fresh;
  logic                          w_push;
  logic                          w_alloc_ok;
  logic [MemoryElementWidth-1:0] w_alloc_id;
  logic [c_cnt_w-1:0]            w_in_use_nxt;
  logic [c_cnt_w-1:0]            w_high_water_nxt;
  logic                          w_err_nxt;

  // Classify the request: bypass, pop, fresh take, push, or failure
  always_comb begin
    w_free_idx       = c_idx_w'(free_id);
    w_pop_idx        = c_idx_w'(r_top - c_cnt_one);
    w_push_idx       = c_idx_w'(r_top);
    w_free_in_range  = ({1'b0, free_id} < c_id_limit);
    w_free_legal     = 1'b0;
    if (free_req && w_free_in_range) begin
      w_free_legal = r_live[w_free_idx];
    end

    // A legal free in the same cycle feeds the allocation directly, so the
    // identifier never touches the stack and stays live throughout.
    w_bypass         = alloc_req && w_free_legal;
    w_stack_nonempty = (r_top != '0);
    w_fresh_avail    = (r_fresh < c_cnt_max);
    w_pop            = alloc_req && !w_bypass && w_stack_nonempty;
    w_take_fresh     = alloc_req && !w_bypass && !w_stack_nonempty && w_fresh_avail;
    // A push can only happen without an alloc (an alloc would have bypassed)
    w_push           = w_free_legal && !w_bypass;
    w_alloc_ok       = w_bypass || w_pop || w_take_fresh;

    // Identifier holds its previous value unless an allocation succeeds
    w_alloc_id = r_alloc_id;
    if (w_bypass) begin
      w_alloc_id = free_id;
    end else if (w_pop) begin
      w_alloc_id = r_freed[w_pop_idx];
    end else if (w_take_fresh) begin
      w_alloc_id = MemoryElementWidth'(r_fresh);
    end
    w_alloc_idx = c_idx_w'(w_alloc_id);

    // Occupancy moves by at most one per cycle; bypass leaves it unchanged
    w_in_use_nxt = r_in_use;
    if (w_pop || w_take_fresh) begin
      w_in_use_nxt = r_in_use + c_cnt_one;
    end else if (w_push) begin
      w_in_use_nxt = r_in_use - c_cnt_one;
    end

    w_high_water_nxt = (w_in_use_nxt > r_high_water) ? w_in_use_nxt : r_high_water;

    w_err_nxt = r_err || (alloc_req && !w_alloc_ok) || (free_req && !w_free_legal);
  end

  // Free stack, fresh counter and liveness bitmap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NArrays; i++) begin
        r_freed[i] <= '0;
      end
      r_top   <= '0;
      r_fresh <= '0;
      r_live  <= '0;
    end else begin
      if (w_push) begin
        r_freed[w_push_idx] <= free_id;
        r_top               <= r_top + c_cnt_one;
        r_live[w_free_idx]  <= 1'b0;
      end
      if (w_pop) begin
        r_top <= r_top - c_cnt_one;
      end
      if (w_take_fresh) begin
        r_fresh <= r_fresh + c_cnt_one;
      end
      if (w_pop || w_take_fresh) begin
        r_live[w_alloc_idx] <= 1'b1;
      end
    end
  end

  // Handshake pulses, returned identifier and statistics
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alloc_done <= 1'b0;
      r_alloc_ok   <= 1'b0;
      r_alloc_id   <= '0;
      r_free_done  <= 1'b0;
      r_free_ok    <= 1'b0;
      r_in_use     <= '0;
      r_high_water <= '0;
      r_err        <= 1'b0;
    end else begin
      r_alloc_done <= alloc_req;
      r_alloc_ok   <= w_alloc_ok;
      r_alloc_id   <= w_alloc_id;
      r_free_done  <= free_req;
      r_free_ok    <= w_free_legal;
      r_in_use     <= w_in_use_nxt;
      r_high_water <= w_high_water_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign alloc_done = r_alloc_done;
  assign alloc_ok   = r_alloc_ok;
  assign alloc_id   = r_alloc_id;
  assign free_done  = r_free_done;
  assign free_ok    = r_free_ok;
  assign in_use     = MemoryElementWidth'(r_in_use);
  assign fresh      = MemoryElementWidth'(r_fresh);
  assign high_water = MemoryElementWidth'(r_high_water);
  assign err_sticky = r_err;

endmodule
`default_nettype wire

// File: tb/tb_array_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_array_allocator
//  Description : Self-checking bench for array_allocator. A four-entry
//                instance and a one-entry instance share clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_array_allocator;

  localparam int W4 = 8;
  localparam int N4 = 4;
  localparam int W1 = 4;
  localparam int N1 = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // Four-entry instance
  logic          a_alloc_req = 1'b0;
  logic          a_free_req  = 1'b0;
  logic [W4-1:0] a_free_id   = '0;
  logic          a_alloc_done, a_alloc_ok, a_free_done, a_free_ok, a_err_sticky;
  logic [W4-1:0] a_alloc_id, a_in_use, a_fresh, a_high_water;

  // One-entry instance
  logic          b_alloc_req = 1'b0;
  logic          b_free_req  = 1'b0;
  logic [W1-1:0] b_free_id   = '0;
  logic          b_alloc_done, b_alloc_ok, b_free_done, b_free_ok, b_err_sticky;
  logic [W1-1:0] b_alloc_id, b_in_use, b_fresh, b_high_water;

  int n_checks = 0;
  int n_errors = 0;

  array_allocator #(.MemoryElementWidth(W4), .NArrays(N4)) u_dut4 (
    .clock(clock), .reset(reset),
    .alloc_req(a_alloc_req), .alloc_done(a_alloc_done), .alloc_ok(a_alloc_ok),
    .alloc_id(a_alloc_id), .free_req(a_free_req), .free_id(a_free_id),
    .free_done(a_free_done), .free_ok(a_free_ok), .in_use(a_in_use),
    .fresh(a_fresh), .high_water(a_high_water), .err_sticky(a_err_sticky)
  );

  array_allocator #(.MemoryElementWidth(W1), .NArrays(N1)) u_dut1 (
    .clock(clock), .reset(reset),
    .alloc_req(b_alloc_req), .alloc_done(b_alloc_done), .alloc_ok(b_alloc_ok),
    .alloc_id(b_alloc_id), .free_req(b_free_req), .free_id(b_free_id),
    .free_done(b_free_done), .free_ok(b_free_ok), .in_use(b_in_use),
    .fresh(b_fresh), .high_water(b_high_water), .err_sticky(b_err_sticky)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit sel;   // 1 = one-entry instance
    bit a;
    bit f;
    int fid;
    bit aok;
    int id;
    bit fok;
    int iu;
    int fr;
    int hw;
    bit err;
  } vec_t;

  vec_t tbl[$];

  // Reference model state (four-entry instance)
  int m_stack[$];
  bit m_live[N4];
  int m_fresh;
  int m_hw;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " a.alloc_done"}, 32'(a_alloc_done), 0);
    check({tag, " a.alloc_ok"},   32'(a_alloc_ok),   0);
    check({tag, " a.alloc_id"},   32'(a_alloc_id),   0);
    check({tag, " a.free_done"},  32'(a_free_done),  0);
    check({tag, " a.free_ok"},    32'(a_free_ok),    0);
    check({tag, " a.in_use"},     32'(a_in_use),     0);
    check({tag, " a.fresh"},      32'(a_fresh),      0);
    check({tag, " a.high_water"}, 32'(a_high_water), 0);
    check({tag, " a.err_sticky"}, 32'(a_err_sticky), 0);
    check({tag, " b.in_use"},     32'(b_in_use),     0);
    check({tag, " b.fresh"},      32'(b_fresh),      0);
    check({tag, " b.alloc_done"}, 32'(b_alloc_done), 0);
  endtask

  // One clock of stimulus followed by a full comparison of the outputs
  task automatic op(input bit sel, input bit a, input bit f, input int fid,
                    input bit aok, input int id, input bit fok,
                    input int iu, input int fr, input int hw, input bit err);
    logic        ad, ao, fd, fo, er;
    logic [31:0] ai, u, fz, h;
    if (sel) begin
      b_alloc_req = a; b_free_req = f; b_free_id = W1'(fid);
    end else begin
      a_alloc_req = a; a_free_req = f; a_free_id = W4'(fid);
    end
    @(posedge clock);
    #1;
    a_alloc_req = 1'b0; a_free_req = 1'b0;
    b_alloc_req = 1'b0; b_free_req = 1'b0;
    if (sel) begin
      ad = b_alloc_done; ao = b_alloc_ok; ai = 32'(b_alloc_id);
      fd = b_free_done;  fo = b_free_ok;  u  = 32'(b_in_use);
      fz = 32'(b_fresh); h  = 32'(b_high_water); er = b_err_sticky;
    end else begin
      ad = a_alloc_done; ao = a_alloc_ok; ai = 32'(a_alloc_id);
      fd = a_free_done;  fo = a_free_ok;  u  = 32'(a_in_use);
      fz = 32'(a_fresh); h  = 32'(a_high_water); er = a_err_sticky;
    end
    check("alloc_done", 32'(ad), 32'(a));
    if (a) check("alloc_ok", 32'(ao), 32'(aok));
    if (a && aok) check("alloc_id", ai, id);
    check("free_done", 32'(fd), 32'(f));
    if (f) check("free_ok", 32'(fo), 32'(fok));
    check("in_use", u, iu);
    check("fresh", fz, fr);
    check("high_water", h, hw);
    check("err_sticky", 32'(er), 32'(err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    m_stack.delete();
    for (int i = 0; i < N4; i++) m_live[i] = 1'b0;
    m_fresh = 0;
    m_hw    = 0;
    m_err   = 1'b0;
  endtask

  // Behavioural model: free legality, LIFO reuse, fresh pool, bypass
  task automatic model_step(input bit a, input bit f, input int fid,
                            output bit aok, output int id, output bit fok,
                            output int iu);
    bit legal;
    legal = 1'b0;
    if (f && fid >= 0 && fid < N4) legal = m_live[fid];
    aok = 1'b0;
    id  = 0;
    if (a && legal) begin
      aok = 1'b1;
      id  = fid;
    end else begin
      if (legal) begin
        m_live[fid] = 1'b0;
        m_stack.push_back(fid);
      end
      if (a) begin
        if (m_stack.size() > 0) begin
          id = m_stack.pop_back(); aok = 1'b1;
        end else if (m_fresh < N4) begin
          id = m_fresh; m_fresh++; aok = 1'b1;
        end
        if (aok) m_live[id] = 1'b1;
      end
    end
    if (a && !aok) m_err = 1'b1;
    if (f && !legal) m_err = 1'b1;
    fok = legal;
    iu = 0;
    for (int i = 0; i < N4; i++) iu += int'(m_live[i]);
    if (iu > m_hw) m_hw = iu;
  endtask

  initial begin
    bit a, f, aok, fok;
    int fid, id, iu;

    // sel a f fid | aok id fok | in_use fresh hw err
    // One-entry instance: alloc/free three times
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0});
      tbl.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0});
    end
    // Four-entry instance: fill, LIFO reuse, illegal frees, exhaustion
    tbl.push_back('{0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 0, 2, 2, 2, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 2, 0, 3, 3, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 1, 2, 3, 3, 0});
    tbl.push_back('{0, 0, 1, 2, 0, 0, 1, 1, 3, 3, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 2, 0, 2, 3, 3, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 0, 3, 3, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 1, 2, 3, 3, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 0, 2, 3, 3, 1});
    tbl.push_back('{0, 0, 1, 7, 0, 0, 0, 2, 3, 3, 1});
    tbl.push_back('{0, 1, 0, 0, 1, 1, 0, 3, 3, 3, 1});
    tbl.push_back('{0, 1, 0, 0, 1, 3, 0, 4, 4, 4, 1});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 4, 4, 4, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 4, 4, 4, 1});

    reset = 1'b1;
    #12;
    check_zero("reset");
    do_reset();

    foreach (tbl[i]) begin
      op(tbl[i].sel, tbl[i].a, tbl[i].f, tbl[i].fid, tbl[i].aok, tbl[i].id,
         tbl[i].fok, tbl[i].iu, tbl[i].fr, tbl[i].hw, tbl[i].err);
    end

    // Exhaustion from a clean state raises err_sticky
    do_reset();
    for (int k = 0; k < 4; k++) op(0, 1, 0, 0, 1, k, 0, k + 1, k + 1, k + 1, 0);
    op(0, 1, 0, 0, 0, 0, 0, 4, 4, 4, 1);

    // Same-cycle bypass, then alloc alongside an illegal free
    do_reset();
    op(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    op(0, 1, 0, 0, 1, 1, 0, 2, 2, 2, 0);
    op(0, 1, 1, 0, 1, 0, 1, 2, 2, 2, 0);
    op(0, 1, 0, 0, 1, 2, 0, 3, 3, 3, 0);
    op(0, 1, 1, 3, 1, 3, 0, 4, 4, 4, 1);

    // Reset asserted between edges clears everything immediately
    do_reset();
    op(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0);
    op(0, 1, 0, 0, 1, 1, 0, 2, 2, 2, 0);
    a_alloc_req = 1'b1;
    @(posedge clock);
    #3;
    reset = 1'b1;
    a_alloc_req = 1'b0;
    #1;
    check_zero("async reset");
    #2;
    reset = 1'b0;
    op(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0);

    // Randomized traffic against the behavioural model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      a   = 1'($urandom_range(0, 1));
      f   = 1'($urandom_range(0, 1));
      fid = int'($urandom_range(0, 5));
      model_step(a, f, fid, aok, id, fok, iu);
      op(0, a, f, fid, aok, id, fok, iu, m_fresh, m_hw, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_allocator.md
# array_allocator

Hardware array-handle allocator for the test-program FPGA: hands out array identifiers on request, recycles freed identifiers through a LIFO free stack, and keeps occupancy statistics. Replaces the inline per-instruction `array`/`free` logic in generated program modules with one shared, parametrised unit that program FSMs drive over a request/done handshake. It adds exhaustion and illegal-free detection, a same-cycle alloc+free path, and a high-water mark.

## Interface
- `MemoryElementWidth`, 12: width of an array identifier and of all count outputs.
- `NArrays`, 16: number of identifiers, 0..NArrays-1. Must be ≥1 and ≤ 2**MemoryElementWidth.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; all state and outputs return to reset values immediately.
- `alloc_req` input 1: request one identifier this cycle.
- `alloc_done` output 1: one-cycle pulse, cycle after `alloc_req`; reset 0.
- `alloc_ok` output 1: qualifies `alloc_done`; 0 means exhausted; reset 0.
- `alloc_id` output MemoryElementWidth: allocated identifier, valid with `alloc_done && alloc_ok`; reset 0.
- `free_req` input 1: return identifier `free_id` this cycle.
- `free_id` input MemoryElementWidth: identifier being freed.
- `free_done` output 1: one-cycle pulse, cycle after `free_req`; reset 0.
- `free_ok` output 1: qualifies `free_done`; 0 means illegal free; reset 0.
- `in_use` output MemoryElementWidth: identifiers currently allocated; reset 0.
- `fresh` output MemoryElementWidth: identifiers ever taken from the never-used pool; reset 0.
- `high_water` output MemoryElementWidth: maximum `in_use` since reset; reset 0.
- `err_sticky` output 1: set on any failed alloc or free, cleared only by reset; reset 0.

## Operation
- State: free stack `freed[NArrays]` with pointer `top` (0..NArrays); counter `fresh`; bitmap `live[NArrays]`.
- Alloc source priority: (1) same-cycle legal free bypass, (2) stack top (`top-1`, then pop), (3) fresh pool (`alloc_id=fresh`, `fresh+1`), (4) none → `alloc_ok=0`.
- Free is legal iff `free_id < NArrays` and `live[free_id]=1`. Legal: clear `live`, push onto stack. Illegal (double free, out of range, never allocated): `free_ok=0`, no state change, `err_sticky` set.
- Simultaneous `alloc_req && free_req` with legal free: alloc receives `free_id` directly, stack untouched, `live[free_id]` stays 1, `in_use` unchanged; both `_done` pulses with `_ok=1`. With illegal free: alloc proceeds as if alone.
- Successful alloc sets `live[id]=1`. `in_use = fresh - top`, kept as a register updated coherently.
- `high_water` updates to `max(high_water, new in_use)` in the same edge as `in_use`.
- Exhaustion: `top==0 && fresh==NArrays` with no bypass. `alloc_ok=0`, `err_sticky` set, no state change.
- LIFO reuse is required: the most recently freed identifier is returned first.

## Timing
- All outputs registered. Request sampled at edge N; `_done`/`_ok`/`alloc_id` valid in cycle N+1 and `_done` is low again at N+2 unless requested again.
- Counts reflect the edge-N operations from cycle N+1.
- Back-to-back requests are accepted every cycle; no stall or ready signal.
- `alloc_id` holds its last value when `alloc_done=0`.
- Reset asserted mid-operation: pulses drop at once, stack and bitmap empty, `fresh=0`; no request sampled while `reset=1`. The first request is sampled at the first edge after deassertion.

## Test plan
- Alloc, free, three times (NArrays=1): each `alloc_id=0`, `alloc_ok=1`, `free_ok=1`. Ends with `fresh=1`, `in_use=0`, `high_water=1`, `err_sticky=0`.
- NArrays=4, four allocs → ids 0,1,2,3. Fifth alloc → `alloc_ok=0`, `err_sticky=1`, `in_use=4`.
- Allocs 0,1,2; free 1 then free 2; two allocs → ids 2 then 1 (LIFO). `fresh=3`, `high_water=3`.
- Free of id 1 twice → second `free_ok=0`. Free of id 7 with NArrays=4 → `free_ok=0`. Counts unchanged.
- Holding 0,1, same-cycle alloc + free(0) → `alloc_id=0`, both ok, `in_use=2`, stack empty; a following alloc → id 2.
- Reset asserted between clock edges after 3 allocs → all outputs 0 immediately; next alloc → id 0.
